// File: rtl/alu32_mul_seq_if.sv
// Request/response bundle of the 32x32->64 shift-and-add multiplier sequencer.
// The Signed request bit exists only when ALU32_MUL_SIGNED_EN is defined.
interface alu32_mul_seq_if;
    logic        Start;
    logic [31:0] In1;
    logic [31:0] In2;
`ifdef ALU32_MUL_SIGNED_EN
    logic        Signed;
`endif
    logic        Busy;
    logic        Done;
    logic [63:0] Out;

    modport master (
        output Start, In1, In2,
`ifdef ALU32_MUL_SIGNED_EN
        output Signed,
`endif
        input  Busy, Done, Out
    );

    modport slave (
        input  Start, In1, In2,
`ifdef ALU32_MUL_SIGNED_EN
        input  Signed,
`endif
        output Busy, Done, Out
    );
endinterface

// File: rtl/alu32_mul_seq.sv
// Multi-cycle 32x32->64 shift-and-add multiplier driving one shared 32-bit CLA adder.
// Define ALU32_MUL_SIGNED_EN to add two's-complement mode (Signed request bit).
module G_Cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s    = p ^ c;
endmodule

module G_FullAdder32 (
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic        CI,
    input  logic        Enable,
    output logic [31:0] Out,
    output logic        CO
);
    logic [8:0]  carry;
    logic [31:0] sum;

    assign carry[0] = CI;

    // Eight 4-bit lookahead blocks rippling carry between them.
    for (genvar gi = 0; gi < 8; gi++) begin : g_blk
        G_Cla4 blk (
            .a  (In1[4*gi +: 4]),
            .b  (In2[4*gi +: 4]),
            .ci (carry[gi]),
            .s  (sum[4*gi +: 4]),
            .co (carry[gi+1])
        );
    end

    assign Out = Enable ? sum : 32'd0;
    assign CO  = Enable ? carry[8] : 1'b0;
endmodule

module alu32_mul_seq (
    input  logic                 CLK,
    input  logic                 RSTn,
    alu32_mul_seq_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, RUN, NEG_LO, NEG_HI} state_t;

    state_t      state;
    logic [31:0] a;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  cnt;
    logic        neg;
    logic        cy;
    logic        busy;
    logic        done;
    logic [63:0] product;

    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic        add_ci;
    logic        add_en;
    logic [31:0] add_out;
    logic        add_co;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_neg;

`ifdef ALU32_MUL_SIGNED_EN
    // Magnitudes of signed operands; 0x80000000 maps to itself and is used as unsigned.
    assign op_a   = (bus.Signed && bus.In1[31]) ? (~bus.In1 + 32'd1) : bus.In1;
    assign op_b   = (bus.Signed && bus.In2[31]) ? (~bus.In2 + 32'd1) : bus.In2;
    assign op_neg = bus.Signed & (bus.In1[31] ^ bus.In2[31]);
`else
    assign op_a   = bus.In1;
    assign op_b   = bus.In2;
    assign op_neg = 1'b0;
`endif

    always_comb begin
        add_in1 = 32'd0;
        add_in2 = 32'd0;
        add_ci  = 1'b0;
        add_en  = 1'b0;
        case (state)
            RUN: begin
                add_in1 = hi;
                add_in2 = lo[0] ? a : 32'd0;
                add_en  = 1'b1;
            end
            NEG_LO: begin
                add_in1 = ~lo;
                add_ci  = 1'b1;
                add_en  = 1'b1;
            end
            NEG_HI: begin
                add_in1 = ~hi;
                add_ci  = cy;
                add_en  = 1'b1;
            end
            default: ;
        endcase
    end

    G_FullAdder32 adder (
        .In1    (add_in1),
        .In2    (add_in2),
        .CI     (add_ci),
        .Enable (add_en),
        .Out    (add_out),
        .CO     (add_co)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            a       <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= 5'd0;
            neg     <= 1'b0;
            cy      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 64'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a     <= op_a;
                        lo    <= op_b;
                        hi    <= 32'd0;
                        cnt   <= 5'd0;
                        neg   <= op_neg;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out becomes the new top bit; the sum's LSB shifts into Lo.
                    hi  <= {add_co, add_out[31:1]};
                    lo  <= {add_out[0], lo[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        if (neg) begin
                            state <= NEG_LO;
                        end else begin
                            product <= {add_co, add_out[31:1], add_out[0], lo[31:1]};
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                NEG_LO: begin
                    lo    <= add_out;
                    cy    <= add_co;
                    state <= NEG_HI;
                end
                NEG_HI: begin
                    hi      <= add_out;
                    product <= {add_out, lo};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.Out  = product;
endmodule

// File: tb/tb_alu32_mul_seq.sv
// Directed-vector bench for alu32_mul_seq: latency, Done pulse, Out hold, reset abort, Start filtering.
// Signed vectors run only when ALU32_MUL_SIGNED_EN is defined.
module tb_alu32_mul_seq;
    logic CLK;
    logic RSTn;
    int   checks;
    int   errors;

    alu32_mul_seq_if bus ();

    alu32_mul_seq dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request, lets it be taken on the next edge, then scrambles the operands.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        bus.In1   = x;
        bus.In2   = y;
`ifdef ALU32_MUL_SIGNED_EN
        bus.Signed = sgn;
`endif
        bus.Start = 1'b1;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        bus.In1   = $urandom;
        bus.In2   = $urandom;
`ifdef ALU32_MUL_SIGNED_EN
        bus.Signed = ~sgn;
`endif
        chk("busy_after_accept", {63'd0, bus.Busy}, 64'd1);
    endtask

    // Returns #1 after the edge that raises Done (or after the cycle budget).
    task automatic wait_done(input string tag, input logic [63:0] exp, input int lat);
        logic [63:0] prev;
        int          n;
        bit          found;
        bit          hold_ok;
        prev    = bus.Out;
        n       = 0;
        found   = 1'b0;
        hold_ok = 1'b1;
        while (!found && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (bus.Done) found = 1'b1;
            else if (bus.Out !== prev) hold_ok = 1'b0;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_out"}, bus.Out, exp);
        chk({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, "_busy_low"}, {63'd0, bus.Busy}, 64'd0);
    endtask

    task automatic pulse_end(input string tag);
        @(posedge CLK);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, bus.Done}, 64'd0);
    endtask

    initial begin
        int dones;
        logic [63:0] done_out;
        checks    = 0;
        errors    = 0;
        bus.Start = 1'b0;
        bus.In1   = 32'd0;
        bus.In2   = 32'd0;
`ifdef ALU32_MUL_SIGNED_EN
        bus.Signed = 1'b0;
`endif
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
        chk("rst_done", {63'd0, bus.Done}, 64'd0);
        chk("rst_out", bus.Out, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        start_op(32'd3, 32'd5, 1'b0);
        wait_done("mul_3x5", 64'h0000_0000_0000_000F, 32);
        pulse_end("mul_3x5");

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("mul_ffxff", 64'hFFFF_FFFE_0000_0001, 32);
        pulse_end("mul_ffxff");

        // A second Start during the run must be dropped.
        start_op(32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        bus.In1   = 32'd2;
        bus.In2   = 32'd2;
        bus.Start = 1'b1;
        @(posedge CLK);
        #1;
        bus.Start = 1'b0;
        dones    = 0;
        done_out = 64'd0;
        repeat (70) begin
            @(posedge CLK);
            #1;
            if (bus.Done) begin
                dones++;
                done_out = bus.Out;
            end
        end
        chk("busy_start_dones", 64'(dones), 64'd1);
        chk("busy_start_out", done_out, 64'd63);

        // Reset mid-run aborts the operation.
        start_op(32'd6, 32'd7, 1'b0);
        repeat (14) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
        chk("abort_done", {63'd0, bus.Done}, 64'd0);
        chk("abort_out", bus.Out, 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        RSTn  = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (bus.Done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        start_op(32'd6, 32'd7, 1'b0);
        wait_done("mul_6x7", 64'd42, 32);
        pulse_end("mul_6x7");

        // Back-to-back: new request presented in the Done cycle.
        start_op(32'd10, 32'd10, 1'b0);
        wait_done("mul_10x10", 64'd100, 32);
        start_op(32'd4, 32'd4, 1'b0);
        wait_done("mul_4x4", 64'd16, 32);
        pulse_end("mul_4x4");

`ifdef ALU32_MUL_SIGNED_EN
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("smul_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 34);
        pulse_end("smul_m3x5");

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("smul_min_sq", 64'h4000_0000_0000_0000, 32);
        pulse_end("smul_min_sq");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu32_mul_seq.md
# alu32_mul_seq

Multi-cycle 32×32→64 multiplier sequencer for the ALU32 gate-level datapath. It performs shift-and-add multiplication with exactly one G_FullAdder32 instance (8×4-bit carry-lookahead chain; ports In1, In2, CI, Enable, Out, CO), which it drives once per cycle. It sits beside the single-cycle ALU ops and gives the ALU a multiply without a combinational array multiplier.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- CLK  input  1  clock; all state updates on rising edge
- RSTn  input  1  asynchronous, active-low reset
- Start  input  1  request; accepted only in IDLE
- In1  input  32  multiplicand, sampled on accept
- In2  input  32  multiplier, sampled on accept
- Signed  input  1  two's-complement mode, sampled on accept; port exists only with ALU32_MUL_SIGNED_EN
- Busy  output  1  high while an operation is in flight (RUN/NEG_LO/NEG_HI); reset 0
- Done  output  1  one-cycle completion pulse; reset 0
- Out  output  64  product register; reset 0; changes only on completion

## Operation
- Registers: A[31:0] multiplicand, Hi[31:0], Lo[31:0] partial product, Cnt[4:0], Neg, Cy; all reset to 0.
- States: IDLE, RUN, NEG_LO, NEG_HI. Reset state is IDLE.
- IDLE: Start=1 → A←In1, Lo←In2, Hi←0, Cnt←0, Neg←0, state←RUN. Start=0 → stay.
- RUN: adder In1=Hi, In2=(Lo[0] ? A : 0), CI=0, Enable=1. Next: Hi←{CO, Out[31:1]}, Lo←{Out[0], Lo[31:1]}, Cnt←Cnt+1.
  - On Cnt=31: if Neg=1 → NEG_LO, else complete.
- NEG_LO: adder In1=~Lo, In2=0, CI=1; Lo←adder Out, Cy←CO, state←NEG_HI.
- NEG_HI: adder In1=~Hi, In2=0, CI=Cy; Hi←adder Out, then complete.
- Complete: Out←{Hi, Lo} as updated that edge, Done←1 for one cycle, state←IDLE.
- Adder Enable=0 in IDLE; its output is ignored there.
- Start while Busy=1: ignored, no queuing, no error.
- Start in the Done cycle: state is already IDLE, so it is accepted. Out keeps the previous product until the new one completes.
- Operands are captured at accept; changes to In1/In2 afterwards have no effect.
- RSTn low at any time, including mid-RUN: all registers and outputs go to 0 immediately; the in-flight result is discarded and no Done is issued.

## Timing
- Accept edge = E0. RUN iterations occur on edges E1…E32.
- Unsigned, or signed with non-negative result: Out valid and Done=1 in the cycle after E32. Latency is 32 cycles from the accept edge to Done.
- Signed with negative result: NEG_LO on E33, NEG_HI on E34, Done after E34. Latency is 34 cycles.
- Busy rises after E0 and falls on the same edge that raises Done.
- Maximum throughput: one operation per 33 (or 35) cycles, using back-to-back Start on the Done cycle.
- Adder path: combinational through the 8-stage ripple of 4-bit CLA blocks. The block adds no extra combinational path to Out (Out is registered).

## Configuration
- ALU32_MUL_SIGNED_EN defined:
  - Signed port present. On accept with Signed=1: A←|In1|, Lo←|In2|, Neg←In1[31]^In2[31].
  - Absolute value is computed combinationally at load; |0x80000000| = 0x80000000, treated as unsigned.
  - Signed=0 behaves as unsigned.
- Not defined: no Signed port, Neg is held at 0, NEG_LO/NEG_HI are unreachable, and the block is unsigned only.

## Test plan
- Reset, then Start with In1=3, In2=5 → Busy=1 for 32 cycles; Done pulse one cycle; Out=0x0000_0000_0000_000F.
- In1=In2=0xFFFFFFFF → Out=0xFFFFFFFE_00000001 after 32 cycles. Exercises CO into Hi on every iteration.
- Start with 7×9; Start pulsed again at cycle 10 with 2×2 → second request ignored; Out=63; exactly one Done.
- Start 6×7; drop RSTn at cycle 15 for 1 cycle → Busy, Done, Out all 0 immediately; no Done follows. Restart 6×7 → Out=42.
- Start 10×10; on the Done cycle, Start with 4×4 → first Out=100 with Done; Out holds 100 for 32 cycles; then Out=16 with Done.
- (ALU32_MUL_SIGNED_EN) Signed=1:
  - -3×5 → Out=0xFFFFFFFF_FFFFFFF1 after 34 cycles.
  - 0x80000000×0x80000000 → Out=0x40000000_00000000 after 32 cycles.
